// File: rtl/ascon_round_counter_gen_pkg.sv
// ascon_pack: shared types and default round schedule for the ASCON round counter
//   round_mode_t  : schedule select encoding (p12 / p8 / p6 / reserved)
//   round_state_t : counter FSM states
//   INIT_P12/P8/P6, NB_ROUNDS_DEF : default start indices and round count
package ascon_pack;
    typedef enum logic [1:0] {MODE_P12, MODE_P8, MODE_P6, MODE_RSV} round_mode_t;
    typedef enum logic {ST_IDLE, ST_RUN} round_state_t;
    localparam int INIT_P12      = 0;
    localparam int INIT_P8       = 4;
    localparam int INIT_P6       = 6;
    localparam int NB_ROUNDS_DEF = 12;
endpackage

// File: rtl/ascon_round_counter_gen_cpt_load.sv
// ascon_cpt_load: loadable, enable-gated counter saturating at max_i, with synchronous clear
//   clock_i, resetb_i : clock, asynchronous active-low reset
//   clr_i             : synchronous clear to 0 (highest priority)
//   load_i/load_val_i : synchronous load
//   en_i              : increment enable, blocked once cpt_o == max_i
//   max_i             : saturation value
//   cpt_o             : counter value
module ascon_cpt_load #(
    parameter int CPT_W = 4
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CPT_W-1:0] load_val_i,
    input  logic             en_i,
    input  logic [CPT_W-1:0] max_i,
    output logic [CPT_W-1:0] cpt_o
);
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i)
            cpt_o <= '0;
        else if (clr_i)
            cpt_o <= '0;
        else if (load_i)
            cpt_o <= load_val_i;
        else if (en_i && cpt_o != max_i)
            cpt_o <= cpt_o + CPT_W'(1);
    end
endmodule

// File: rtl/ascon_round_counter_gen.sv
// ascon_round_counter_gen: ASCON permutation round counter with start/done handshake and per-mode start round
//   clock_i, resetb_i : clock, asynchronous active-low reset
//   start_i, mode_i   : start request and schedule select (0=p12, 1=p8, 2=p6, 3=reserved -> INIT_A)
//   en_i              : round advance, stalls the counter when low
//   abort_i           : synchronous cancel, returns to idle with cpt 0
//   cpt_o             : current round index (round-constant select)
//   busy_o, last_o    : running, running on the last round
//   done_o            : one-cycle pulse after the last round is consumed
//   err_o             : sticky misuse flag, only with ROUND_CNT_ERR_EN defined
module ascon_round_counter_gen
    import ascon_pack::*;
#(
    parameter int CPT_W     = 4,
    parameter int NB_ROUNDS = NB_ROUNDS_DEF,
    parameter int INIT_A    = INIT_P12,
    parameter int INIT_B    = INIT_P8,
    parameter int INIT_C    = INIT_P6
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic             en_i,
    input  logic             abort_i,
    output logic [CPT_W-1:0] cpt_o,
    output logic             busy_o,
    output logic             last_o,
    output logic             done_o
`ifdef ROUND_CNT_ERR_EN
   ,output logic             err_o
`endif
);
    localparam logic [CPT_W-1:0] LAST = CPT_W'(NB_ROUNDS - 1);

    if (INIT_A > NB_ROUNDS - 1 || INIT_B > NB_ROUNDS - 1 || INIT_C > NB_ROUNDS - 1 ||
        (2 ** CPT_W) <= NB_ROUNDS - 1) begin : g_bad_cfg
        $error("ascon_round_counter_gen: init index beyond last round or CPT_W too narrow");
    end

    round_state_t     state_q, state_d;
    round_mode_t      mode;
    logic [CPT_W-1:0] init_val;
    logic             run, complete, load;

    assign mode     = round_mode_t'(mode_i);
    assign init_val = (mode == MODE_P8) ? CPT_W'(INIT_B) :
                      (mode == MODE_P6) ? CPT_W'(INIT_C) : CPT_W'(INIT_A);
    assign run      = state_q == ST_RUN;
    assign complete = run && en_i && cpt_o == LAST;
    // A start is only honoured when idle or on the completion edge (back-to-back reload).
    assign load     = !abort_i && start_i && (!run || complete);
    assign busy_o   = run;
    assign last_o   = run && cpt_o == LAST;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        state_d = abort_i                 ? ST_IDLE :
                  !run                    ? (start_i ? ST_RUN : ST_IDLE) :
                  (complete && !start_i)  ? ST_IDLE : ST_RUN;
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i)
            done_o <= 1'b0;
        else
            done_o <= !abort_i && complete;
    end

`ifdef ROUND_CNT_ERR_EN
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i)
            err_o <= 1'b0;
        else if (abort_i)
            err_o <= 1'b0;
        else if (start_i && ((run && !complete) || mode == MODE_RSV))
            err_o <= 1'b1;
    end
`endif

    ascon_cpt_load #(.CPT_W(CPT_W)) u_cpt (
        .clock_i   (clock_i),
        .resetb_i  (resetb_i),
        .clr_i     (abort_i),
        .load_i    (load),
        .load_val_i(init_val),
        .en_i      (run && en_i),
        .max_i     (LAST),
        .cpt_o     (cpt_o)
    );
endmodule

// File: tb/tb_ascon_round_counter_gen.sv
// tb_ascon_round_counter_gen: directed self-checking bench for ascon_round_counter_gen
module tb_ascon_round_counter_gen;
    logic       clock_i = 1'b0;
    logic       resetb_i = 1'b0;
    logic       start_i = 1'b0;
    logic [1:0] mode_i = 2'd0;
    logic       en_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [3:0] cpt_o;
    logic       busy_o, last_o, done_o;
`ifdef ROUND_CNT_ERR_EN
    logic       err_o;
`endif
    int tests = 0;
    int fails = 0;

    ascon_round_counter_gen dut (
        .clock_i (clock_i),
        .resetb_i(resetb_i),
        .start_i (start_i),
        .mode_i  (mode_i),
        .en_i    (en_i),
        .abort_i (abort_i),
        .cpt_o   (cpt_o),
        .busy_o  (busy_o),
        .last_o  (last_o),
        .done_o  (done_o)
`ifdef ROUND_CNT_ERR_EN
       ,.err_o   (err_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #2;
        chk("rst_cpt", int'(cpt_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_last", int'(last_o), 0);
        chk("rst_done", int'(done_o), 0);
        resetb_i = 1'b1;
        tick();
        // mode 0, en held high
        start_i = 1'b1; mode_i = 2'd0; en_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("p12_first", int'(cpt_o), 0);
        chk("p12_busy", int'(busy_o), 1);
        for (int i = 1; i < 12; i++) begin
            tick();
            chk("p12_cpt", int'(cpt_o), i);
            chk("p12_last", int'(last_o), i == 11 ? 1 : 0);
            chk("p12_nodone", int'(done_o), 0);
        end
        tick();
        chk("p12_done", int'(done_o), 1);
        chk("p12_idle", int'(busy_o), 0);
        chk("p12_hold", int'(cpt_o), 11);
        chk("p12_last_idle", int'(last_o), 0);
        tick();
        chk("p12_done_once", int'(done_o), 0);
        chk("idle_hold", int'(cpt_o), 11);
        // modes 1 and 2 with en toggling
        for (int m = 1; m < 3; m++) begin
            start_i = 1'b1; mode_i = 2'(m); en_i = 1'b0;
            tick();
            start_i = 1'b0;
            for (int v = (m == 1 ? 4 : 6); v < 12; v++) begin
                en_i = 1'b0;
                tick();
                chk("tog_hold", int'(cpt_o), v);
                chk("tog_last", int'(last_o), v == 11 ? 1 : 0);
                chk("tog_nodone", int'(done_o), 0);
                en_i = 1'b1;
                tick();
                if (v < 11) chk("tog_inc", int'(cpt_o), v + 1);
                else chk("tog_done", int'(done_o), 1);
            end
            chk("tog_idle", int'(busy_o), 0);
        end
        // back-to-back: mode 0 run completed with mode 2 restart
        start_i = 1'b1; mode_i = 2'd0; en_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (11) tick();
        chk("b2b_at_last", int'(cpt_o), 11);
        start_i = 1'b1; mode_i = 2'd2;
        tick();
        start_i = 1'b0;
        chk("b2b_done", int'(done_o), 1);
        chk("b2b_cpt", int'(cpt_o), 6);
        chk("b2b_busy", int'(busy_o), 1);
        tick();
        chk("b2b_next", int'(cpt_o), 7);
        chk("b2b_done_once", int'(done_o), 0);
        repeat (5) tick();
        chk("b2b_end_done", int'(done_o), 1);
        // abort at cpt 5 with simultaneous start
        start_i = 1'b1; mode_i = 2'd0;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        chk("abt_pre", int'(cpt_o), 5);
        abort_i = 1'b1; start_i = 1'b1; mode_i = 2'd1;
        tick();
        abort_i = 1'b0; start_i = 1'b0;
        chk("abt_cpt", int'(cpt_o), 0);
        chk("abt_busy", int'(busy_o), 0);
        chk("abt_done", int'(done_o), 0);
        tick();
        chk("abt_stay", int'(busy_o), 0);
        chk("abt_nodone", int'(done_o), 0);
        // restart after abort, and start in RUN is ignored
        start_i = 1'b1; mode_i = 2'd1;
        tick();
        chk("rst_p8", int'(cpt_o), 4);
        mode_i = 2'd2;
        tick();
        start_i = 1'b0;
        chk("run_start_ign", int'(cpt_o), 5);
        tick();
        chk("pre_reset", int'(cpt_o), 6);
        tick();
        chk("pre_reset7", int'(cpt_o), 7);
        // asynchronous reset mid-run, checked before the next edge
        #1 resetb_i = 1'b0;
        #1;
        chk("arst_cpt", int'(cpt_o), 0);
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_done", int'(done_o), 0);
        resetb_i = 1'b1;
        tick();
        // reserved mode loads INIT_A
        start_i = 1'b1; mode_i = 2'd3;
        tick();
        start_i = 1'b0;
        chk("rsv_cpt", int'(cpt_o), 0);
        chk("rsv_busy", int'(busy_o), 1);
`ifdef ROUND_CNT_ERR_EN
        chk("err_rsv", int'(err_o), 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("err_clr", int'(err_o), 0);
        start_i = 1'b1; mode_i = 2'd0;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("err_run", int'(err_o), 1);
        chk("err_cnt", int'(cpt_o), 4);
        repeat (7) tick();
        chk("err_last", int'(cpt_o), 11);
        tick();
        chk("err_done", int'(done_o), 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("err_abort", int'(err_o), 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
